// File: rtl/instruction_memory.sv
// Word-organised instruction store for the IF stage: combinational fetch, default program image.
// Define IMEM_PROG_PORT_EN for a writable memory with a clocked load port; otherwise a constant ROM.
module instruction_memory #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] program_counter,
    output logic [31:0] instruction,
    output logic        misaligned,
    output logic        out_of_range,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned WORD_W = 32;

    logic [AW-1:0]     rd_idx;
    logic [WORD_W-1:0] rd_word;

    // Default program image: a short ALU exercise, NOPs elsewhere.
    function automatic logic [WORD_W-1:0] default_word(input logic [AW-1:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            AW'(0):  w = 32'h0050_0093;
            AW'(1):  w = 32'h00A0_0113;
            AW'(2):  w = 32'h0020_81B3;
            AW'(3):  w = 32'h4020_8233;
            AW'(4):  w = 32'h0020_F2B3;
            AW'(5):  w = 32'h0020_E333;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    assign rd_idx       = program_counter[AW+1:2];
    assign misaligned   = |program_counter[1:0];
    assign out_of_range = |program_counter[31:AW+2];
    assign instruction  = out_of_range ? NOP_WORD : rd_word;

`ifdef IMEM_PROG_PORT_EN
    logic [WORD_W-1:0] mem [DEPTH];
    logic              wr_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;

    // Writes stay blocked until one full edge has passed since reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready <= 1'b0;
        end else begin
            wr_ready <= 1'b1;
        end
    end

    assign wr_idx = prog_addr[AW+1:2];
    assign wr_en  = prog_we && wr_ready && (prog_addr[1:0] == 2'b00)
                    && !(|prog_addr[31:AW+2]);

    // Reset reloads every word with the default image and holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= default_word(AW'(i));
            end
        end else if (wr_en) begin
            mem[wr_idx] <= prog_data;
        end
    end

    assign rd_word = mem[rd_idx];
`else
    logic unused_load_port;

    assign rd_word          = default_word(rd_idx);
    assign unused_load_port = ^{clk, rst_n, prog_we, prog_addr, prog_data};
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed plan steps then randomized fetch/write traffic.
module tb_instruction_memory;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        misaligned;
    logic        out_of_range;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    int          errors = 0;
    int          checks = 0;
    int          edges_since_rst = 0;
    logic [31:0] model [DEPTH];

    instruction_memory #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .program_counter (program_counter),
        .instruction     (instruction),
        .misaligned      (misaligned),
        .out_of_range    (out_of_range),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) edges_since_rst = edges_since_rst + 1;
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = NOP;
        model[0] = 32'h0050_0093;
        model[1] = 32'h00A0_0113;
        model[2] = 32'h0020_81B3;
        model[3] = 32'h4020_8233;
        model[4] = 32'h0020_F2B3;
        model[5] = 32'h0020_E333;
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s pc=%h observed=%h expected=%h", tag, program_counter, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s pc=%h observed=%b expected=%b", tag, program_counter, got, exp);
        end
    endtask

    // Drive a PC, wait off-edge, compare all three outputs against the model.
    task automatic fetch(input string tag, input logic [31:0] pc);
        logic oor;
        program_counter = pc;
        #1;
        oor = (pc >= DEPTH * 4);
        check32({tag, "_instr"}, instruction, oor ? NOP : model[pc[7:2]]);
        check1({tag, "_mis"}, misaligned, pc % 4 != 0);
        check1({tag, "_oor"}, out_of_range, oor);
    endtask

    // One load-port write; the addressed word is read before and after the edge.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic ok;
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
`ifdef IMEM_PROG_PORT_EN
        ok = (addr % 4 == 0) && (addr < DEPTH * 4) && (edges_since_rst >= 1);
`else
        ok = 1'b0;
`endif
        fetch({tag, "_pre"}, addr);
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        if (ok) model[addr[7:2]] = data;
        fetch({tag, "_post"}, addr);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        fetch("rst_async", 32'd8);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        edges_since_rst = 0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        rst_n = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        program_counter = '0;
        model_reset();
        #3;
        fetch("in_reset_pc0", 32'd0);
        fetch("in_reset_pc20", 32'd20);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        edges_since_rst = 0;

        for (int i = 0; i < 6; i++) begin
            fetch("seq", 32'(i * 4));
            #9;
        end
        fetch("mis_pc6", 32'd6);
        fetch("mis_oor_pc103", 32'h103);
        fetch("oor_pc256", 32'd256);
        fetch("unused_pc252", 32'd252);

        do_write("wr8", 32'd8, 32'hDEAD_BEEF);
        do_write("wr9_drop", 32'd9, 32'h1234_5678);
        do_write("wr512_drop", 32'd512, 32'h8765_4321);
        for (int i = 0; i < DEPTH; i++) fetch("scan", 32'(i * 4));

        pulse_reset();
        fetch("after_rst_pc8", 32'd8);
        do_write("first_edge_drop", 32'd8, 32'h1111_1111);
        do_write("second_edge_ok", 32'd8, 32'h2222_2222);

        // Write attempted while reset is held low must not land.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        prog_we = 1'b1;
        prog_addr = 32'd12;
        prog_data = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        prog_we = 1'b0;
        fetch("wr_during_rst", 32'd12);
        rst_n = 1'b1;
        edges_since_rst = 0;

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                    do_write("rnd_wr", a, $urandom);
                end
                4: begin
                    a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
                    d = $urandom;
                    do_write("rnd_wr_any", a, d);
                end
                5: begin
                    if ($urandom_range(0, 9) == 0) pulse_reset();
                    else fetch("rnd_fetch_big", $urandom);
                end
                default: fetch("rnd_fetch", 32'($urandom_range(0, DEPTH * 4 + 16)));
            endcase
        end
        for (int i = 0; i < DEPTH; i++) fetch("final_scan", 32'(i * 4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
